// File: rtl/decoder_pulse_if.sv
// Code/handshake bundle between an upstream encoder and the pulse decoder.
interface decoder_pulse_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             a0;
    logic             a1;
    logic             in_valid;
    logic             in_ready;
    logic             cancel;
    logic             y0;
    logic             y1;
    logic             y2;
    logic             y3;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] decode_cnt;

    modport master (
        output a0, a1, in_valid, cancel,
        input  in_ready, y0, y1, y2, y3, busy, done, decode_cnt
    );

    modport slave (
        input  a0, a1, in_valid, cancel,
        output in_ready, y0, y1, y2, y3, busy, done, decode_cnt
    );
endinterface

// File: rtl/decoder_pulse.sv
// Sequential 2-to-4 decoder: holds the one-hot line for PULSE_LEN cycles after each accepted
// code, then enforces GAP_LEN idle cycles. Counts accepted codes and pulses done on natural end.
module decoder_pulse #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1,
    parameter int unsigned CNT_W     = 8
) (
    input logic            clk,
    input logic            rst,
    decoder_pulse_if.slave bus
);
    localparam int unsigned MaxLen = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned TimerW = (MaxLen < 1) ? 1 : $clog2(MaxLen + 1);

    typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

    state_e             state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [1:0]         code_q, code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [3:0]         y_q, y_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    // Next state; timer holds the number of cycles remaining in the current state after this one.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    code_d  = {bus.a1, bus.a0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    timer_d = TimerW'(PULSE_LEN - 1);
                    state_d = StActive;
                end
            end
            StActive: begin
                if (bus.cancel || timer_q == '0) begin
                    // A cancel, even in the final cycle, suppresses done.
                    done_d = !bus.cancel;
                    if (GAP_LEN > 0) begin
                        timer_d = TimerW'(GAP_LEN - 1);
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StGap: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        y_d     = (state_d == StActive) ? (4'b0001 << code_d) : 4'b0000;
        ready_d = (state_d == StIdle);
        busy_d  = !ready_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            y_q     <= 4'b0000;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            y_q     <= y_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.y0         = y_q[0];
    assign bus.y1         = y_q[1];
    assign bus.y2         = y_q[2];
    assign bus.y3         = y_q[3];
    assign bus.in_ready   = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.decode_cnt = cnt_q;
endmodule

// File: tb/tb_decoder_pulse.sv
// Bench for decoder_pulse: two instances (default timing, and gapless single-cycle with a 2-bit
// counter) checked every cycle against a timeline model, plus directed literal expectations.
module tb_decoder_pulse;
    localparam int P0 = 4, G0 = 1, W0 = 8;
    localparam int P1 = 1, G1 = 0, W1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Applied stimulus per instance.
    logic       s_rst[2];
    logic       s_valid[2];
    logic       s_cancel[2];
    logic [1:0] s_code[2];

    // Stimulus for the next cycle, staged by the test sequence.
    logic       n_rst[2];
    logic       n_valid[2];
    logic       n_cancel[2];
    logic [1:0] n_code[2];

    wire [3:0] o_y[2];
    wire       o_rdy[2];
    wire       o_busy[2];
    wire       o_done[2];
    wire [7:0] o_cnt[2];

    decoder_pulse_if #(.CNT_W(W0)) bus_a ();
    decoder_pulse_if #(.CNT_W(W1)) bus_b ();

    decoder_pulse #(.PULSE_LEN(P0), .GAP_LEN(G0), .CNT_W(W0)) dut_a (
        .clk(clk), .rst(s_rst[0]), .bus(bus_a)
    );
    decoder_pulse #(.PULSE_LEN(P1), .GAP_LEN(G1), .CNT_W(W1)) dut_b (
        .clk(clk), .rst(s_rst[1]), .bus(bus_b)
    );

    assign bus_a.a0       = s_code[0][0];
    assign bus_a.a1       = s_code[0][1];
    assign bus_a.in_valid = s_valid[0];
    assign bus_a.cancel   = s_cancel[0];
    assign bus_b.a0       = s_code[1][0];
    assign bus_b.a1       = s_code[1][1];
    assign bus_b.in_valid = s_valid[1];
    assign bus_b.cancel   = s_cancel[1];

    assign o_y[0]    = {bus_a.y3, bus_a.y2, bus_a.y1, bus_a.y0};
    assign o_y[1]    = {bus_b.y3, bus_b.y2, bus_b.y1, bus_b.y0};
    assign o_rdy[0]  = bus_a.in_ready;
    assign o_rdy[1]  = bus_b.in_ready;
    assign o_busy[0] = bus_a.busy;
    assign o_busy[1] = bus_b.busy;
    assign o_done[0] = bus_a.done;
    assign o_done[1] = bus_b.done;
    assign o_cnt[0]  = bus_a.decode_cnt;
    assign o_cnt[1]  = {6'b0, bus_b.decode_cnt};

    // Timeline model: pulse occupies cycles t_acc+1 .. t_end-1, done at t_end if it ended
    // naturally, ready again from rdy_from.
    int   plen[2];
    int   glen[2];
    int   cmod[2];
    int   t_acc[2];
    int   t_end[2];
    int   rdy_from[2];
    bit   natural[2];
    bit   armed[2];
    int   mcode[2];
    int   mcnt[2];
    int   m;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, m, act, exp);
        end
    endtask

    task automatic compare(input int i);
        logic [3:0] ey;
        bit         erdy;
        if (!armed[i]) return;
        ey   = (t_acc[i] < m && m < t_end[i]) ? (4'b0001 << mcode[i]) : 4'b0000;
        erdy = (m >= rdy_from[i]);
        chk($sformatf("dut%0d_y", i),     {4'b0, o_y[i]},   {4'b0, ey});
        chk($sformatf("dut%0d_done", i),  {7'b0, o_done[i]},
            {7'b0, (natural[i] && m == t_end[i])});
        chk($sformatf("dut%0d_ready", i), {7'b0, o_rdy[i]},  {7'b0, erdy});
        chk($sformatf("dut%0d_busy", i),  {7'b0, o_busy[i]}, {7'b0, !erdy});
        chk($sformatf("dut%0d_cnt", i),   o_cnt[i],          8'(mcnt[i]));
    endtask

    task automatic model_update(input int i);
        if (n_rst[i]) begin
            armed[i]    = 1'b1;
            t_acc[i]    = -100;
            t_end[i]    = m + 1;
            natural[i]  = 1'b0;
            rdy_from[i] = m + 1;
            mcnt[i]     = 0;
        end else if (armed[i]) begin
            if (m >= rdy_from[i] && n_valid[i]) begin
                t_acc[i]    = m;
                mcode[i]    = int'(n_code[i]);
                mcnt[i]     = (mcnt[i] + 1) % cmod[i];
                t_end[i]    = m + plen[i] + 1;
                natural[i]  = 1'b1;
                rdy_from[i] = t_end[i] + glen[i];
            end else if (t_acc[i] < m && m < t_end[i] && n_cancel[i]) begin
                t_end[i]    = m + 1;
                natural[i]  = 1'b0;
                rdy_from[i] = m + 1 + glen[i];
            end
        end
    endtask

    // Compare cycle m, then apply the staged inputs for cycle m and advance the model.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) compare(i);
        for (int i = 0; i < 2; i++) begin
            s_rst[i]    = n_rst[i];
            s_valid[i]  = n_valid[i];
            s_cancel[i] = n_cancel[i];
            s_code[i]   = n_code[i];
            model_update(i);
        end
        m++;
    endtask

    task automatic wait_idle(input int i);
        for (int k = 0; k < 20 && m < rdy_from[i]; k++) step();
    endtask

    logic [1:0] held[13];

    initial begin
        checks = 0;
        errors = 0;
        m      = 0;
        plen   = '{P0, P1};
        glen   = '{G0, G1};
        cmod   = '{1 << W0, 1 << W1};
        for (int i = 0; i < 2; i++) begin
            armed[i] = 1'b0; t_acc[i] = -100; t_end[i] = 0; rdy_from[i] = 0;
            natural[i] = 1'b0; mcode[i] = 0; mcnt[i] = 0;
            n_rst[i] = 1'b1; n_valid[i] = 1'b0; n_cancel[i] = 1'b0; n_code[i] = 2'b00;
            s_rst[i] = 1'b1; s_valid[i] = 1'b0; s_cancel[i] = 1'b0; s_code[i] = 2'b00;
        end

        // Reset.
        step();
        step();
        n_rst[0] = 1'b0;
        n_rst[1] = 1'b0;
        step();
        chk("rst_ready", {7'b0, o_rdy[0]}, 8'd1);
        chk("rst_busy",  {7'b0, o_busy[0]}, 8'd0);
        chk("rst_y",     {4'b0, o_y[0]}, 8'd0);
        chk("rst_cnt",   o_cnt[0], 8'd0);

        // Single code 10.
        n_valid[0] = 1'b1; n_code[0] = 2'b10;
        step();
        n_valid[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k <= 4) chk("single_y2", {4'b0, o_y[0]}, 8'h04);
            if (k == 5) begin
                chk("single_y_off", {4'b0, o_y[0]}, 8'h00);
                chk("single_done",  {7'b0, o_done[0]}, 8'd1);
            end
            if (k == 6) begin
                chk("single_ready", {7'b0, o_rdy[0]}, 8'd1);
                chk("single_cnt",   o_cnt[0], 8'd1);
            end
        end

        // All four codes after a fresh reset.
        n_rst[0] = 1'b1; step(); n_rst[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wait_idle(0);
            n_valid[0] = 1'b1; n_code[0] = 2'(c);
            step();
            n_valid[0] = 1'b0;
            step();
            step();
            chk("allcodes_y", {4'b0, o_y[0]}, 8'(1 << c));
        end
        wait_idle(0);
        chk("allcodes_cnt", o_cnt[0], 8'd4);

        // Held in_valid with a changing code: accepts at cycles 0, 6, 12 only.
        n_valid[0] = 1'b1;
        for (int k = 0; k < 13; k++) begin
            held[k]   = 2'($urandom_range(0, 3));
            n_code[0] = held[k];
            step();
            if (k == 1) chk("held_y1", {4'b0, o_y[0]}, 8'(1 << held[0]));
            if (k == 7) chk("held_y7", {4'b0, o_y[0]}, 8'(1 << held[6]));
            if (k == 12) chk("held_ready12", {7'b0, o_rdy[0]}, 8'd1);
        end
        n_valid[0] = 1'b0;
        step();
        chk("held_y13", {4'b0, o_y[0]}, 8'(1 << held[12]));
        chk("held_cnt", o_cnt[0], 8'd7);

        // Cancel code 11 in cycle 2.
        wait_idle(0);
        n_valid[0] = 1'b1; n_code[0] = 2'b11;
        step();
        n_valid[0] = 1'b0;
        step();
        chk("cancel_y_c1", {4'b0, o_y[0]}, 8'h08);
        n_cancel[0] = 1'b1;
        step();
        chk("cancel_y_c2", {4'b0, o_y[0]}, 8'h08);
        n_cancel[0] = 1'b0;
        step();
        chk("cancel_y_c3",    {4'b0, o_y[0]}, 8'h00);
        chk("cancel_done_c3", {7'b0, o_done[0]}, 8'd0);
        step();
        chk("cancel_ready_c4", {7'b0, o_rdy[0]}, 8'd1);
        chk("cancel_done_c4",  {7'b0, o_done[0]}, 8'd0);

        // Reset in cycle 2 of a pulse.
        wait_idle(0);
        n_valid[0] = 1'b1; n_code[0] = 2'b01;
        step();
        n_valid[0] = 1'b0;
        step();
        n_rst[0] = 1'b1;
        step();
        n_rst[0] = 1'b0;
        step();
        chk("midrst_y",     {4'b0, o_y[0]}, 8'h00);
        chk("midrst_busy",  {7'b0, o_busy[0]}, 8'd0);
        chk("midrst_cnt",   o_cnt[0], 8'd0);
        chk("midrst_ready", {7'b0, o_rdy[0]}, 8'd1);

        // Gapless single-cycle instance: 2-cycle accept period, 2-bit counter wraps.
        n_valid[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            n_code[1] = 2'($urandom_range(0, 3));
            step();
            if (k == 2) chk("wrap_done2", {7'b0, o_done[1]}, 8'd1);
            if (k == 1) chk("wrap_cnt1", o_cnt[1], 8'd1);
            if (k == 3) chk("wrap_cnt3", o_cnt[1], 8'd2);
            if (k == 5) chk("wrap_cnt5", o_cnt[1], 8'd3);
            if (k == 7) chk("wrap_cnt7", o_cnt[1], 8'd0);
            if (k == 9) chk("wrap_cnt9", o_cnt[1], 8'd1);
        end
        n_valid[1] = 1'b0;

        // Random traffic on both instances.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                n_rst[i]    = ($urandom_range(0, 99) == 0);
                n_valid[i]  = 1'($urandom_range(0, 1));
                n_cancel[i] = ($urandom_range(0, 9) == 0);
                n_code[i]   = 2'($urandom_range(0, 3));
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            n_rst[i] = 1'b0; n_valid[i] = 1'b0; n_cancel[i] = 1'b0;
        end
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decoder_pulse.md
Name: decoder_pulse

Overview:
- Sequential 2-to-4 decoder; the receiving end of the 4-to-2 priority encoder's code bits.
- Accepts a 2-bit code {a1,a0} over a valid/ready handshake.
- Drives the matching one-hot line y0..y3 for a fixed number of cycles, then forces a programmable gap before accepting the next code.
- Also keeps a wrap-around count of accepted codes and flags natural completion with a one-cycle done pulse.

Parameters:
- PULSE_LEN, 4: cycles each one-hot output is held; legal range >= 1.
- GAP_LEN, 1: forced all-zero cycles after a pulse before returning to IDLE; legal range >= 0.
- CNT_W, 8: width of decode_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a0  input  1  code bit 0.
- a1  input  1  code bit 1.
- in_valid  input  1  code valid.
- in_ready  output  1  block can accept a code.
- cancel  input  1  abort the current pulse.
- y0  output  1  one-hot line 0 (code 00).
- y1  output  1  one-hot line 1 (code 01).
- y2  output  1  one-hot line 2 (code 10).
- y3  output  1  one-hot line 3 (code 11).
- busy  output  1  high in ACTIVE or GAP.
- done  output  1  one-cycle pulse on natural pulse completion.
- decode_cnt  output  CNT_W  count of accepted codes.

Behaviour:
- Interface: one clock domain, clk. rst is synchronous and active-high. All outputs are registered.
- Reset: when rst is sampled high, the next state is IDLE, y0..y3=0, busy=0, done=0, decode_cnt=0, in_ready=1, and timers clear. Reset overrides every other input in the same cycle, including mid-pulse (outputs drop on the next edge).
- States: IDLE, ACTIVE, GAP.
- IDLE:
  - in_ready=1, busy=0, y=0.
  - A transfer occurs when in_valid=1 and in_ready=1 on an edge. Code {a1,a0} is latched, decode_cnt increments, next state is ACTIVE.
  - a0/a1 are don't-care when in_valid=0.
- ACTIVE:
  - Exactly one of y0..y3 is high: the one matching the latched code. in_ready=0, busy=1.
  - Timing: a transfer in cycle T drives the one-hot line in cycles T+1 through T+PULSE_LEN.
  - After the last ACTIVE cycle: if GAP_LEN>0 go to GAP, else go to IDLE.
  - done=1 for exactly one cycle, in the first cycle after the last ACTIVE cycle (y already 0).
- GAP:
  - y=0, in_ready=0, busy=1. Lasts exactly GAP_LEN cycles, then IDLE.
- Throughput: in_ready next rises in cycle T+PULSE_LEN+GAP_LEN+1, so the minimum accept period is PULSE_LEN+GAP_LEN+1 cycles.
- in_valid while in_ready=0: ignored. Nothing is latched and the count is unchanged; the upstream block holds the code.
- cancel:
  - Sampled high in any ACTIVE cycle: y drops to 0 on the next edge. The next state is GAP (or IDLE if GAP_LEN=0).
  - done is not asserted for a cancelled pulse.
  - cancel in IDLE or GAP is ignored. cancel in the final ACTIVE cycle behaves as a cancel: no done.
- decode_cnt: unsigned, increments by 1 per transfer, wraps from 2^CNT_W-1 to 0. No saturation.
- Timer width: internal timer sized ceil(log2(max(PULSE_LEN,GAP_LEN)+1)), minimum 1 bit.
- Invariant: y0..y3 are never more than one-hot in any cycle.

Test Plan:
- Reset then single code: PULSE_LEN=4, GAP_LEN=1, code 10 with in_valid in cycle 0 -> y2=1 in cycles 1-4, all y=0 from cycle 5, done=1 in cycle 5 only, in_ready=1 again in cycle 6, decode_cnt=1.
- All codes: send 00, 01, 10, 11 in sequence -> y0, y1, y2, y3 respectively, each high for 4 cycles; never two lines high; decode_cnt=4.
- Held in_valid: in_valid=1 continuously with a changing code -> transfers only in cycles 0, 6, 12; codes present in other cycles are not latched.
- Cancel: code 11 in cycle 0, cancel in cycle 2 -> y3 high in cycles 1-2, 0 from cycle 3, no done, in_ready=1 in cycle 4.
- Reset mid-pulse: rst in cycle 2 of ACTIVE -> next cycle y=0, busy=0, decode_cnt=0, in_ready=1.
- Wrap and gapless: CNT_W=2, GAP_LEN=0, PULSE_LEN=1, five transfers -> accept period 2 cycles, decode_cnt goes 1,2,3,0,1.
